// File: rtl/mvm_uart_framer_if.sv
// Byte-link and AXI-Stream bundle between the UART framer and its neighbours.
// master = framer side, slave = UART / matvec engine side.
interface mvm_uart_framer_if #(
  parameter int unsigned W_KX    = 576,
  parameter int unsigned W_Y_BUS = 152
) ();
  logic               s_byte_valid;
  logic [7:0]         s_byte_data;
  logic               m_byte_valid;
  logic               m_byte_ready;
  logic [7:0]         m_byte_data;
  logic               m_axis_kx_tvalid;
  logic               m_axis_kx_tready;
  logic [W_KX-1:0]    m_axis_kx_tdata;
  logic               s_axis_y_tvalid;
  logic               s_axis_y_tready;
  logic [W_Y_BUS-1:0] s_axis_y_tdata;

  modport master (
    input  s_byte_valid, s_byte_data, m_byte_ready, m_axis_kx_tready,
           s_axis_y_tvalid, s_axis_y_tdata,
    output m_byte_valid, m_byte_data, m_axis_kx_tvalid, m_axis_kx_tdata,
           s_axis_y_tready
  );

  modport slave (
    output s_byte_valid, s_byte_data, m_byte_ready, m_axis_kx_tready,
           s_axis_y_tvalid, s_axis_y_tdata,
    input  m_byte_valid, m_byte_data, m_axis_kx_tvalid, m_axis_kx_tdata,
           s_axis_y_tready
  );
endinterface

// File: rtl/mvm_uart_framer.sv
// UART command-frame parser / ACK+Y responder for axis_matvec_mul; K stays resident.
// Optional inter-byte timeout enabled by defining MVM_FRAMER_TIMEOUT_EN.
module mvm_uart_framer #(
  parameter int unsigned R       = 8,
  parameter int unsigned C       = 8,
  parameter int unsigned W_X     = 8,
  parameter int unsigned W_K     = 8,
  parameter int unsigned W_Y_OUT = 32,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  mvm_uart_framer_if.master   bus,
  output logic                frame_err
);
  localparam int unsigned W_Y   = W_X + W_K + $clog2(C);
  localparam int unsigned W_KB  = R * C * W_K;
  localparam int unsigned W_XB  = C * W_X;
  localparam int unsigned NKB   = W_KB / 8;
  localparam int unsigned NXB   = W_XB / 8;
  localparam int unsigned NYB   = R * W_Y_OUT / 8;
  localparam int unsigned RXC_W = $clog2(((NKB > NXB) ? NKB : NXB) + 1);
  localparam int unsigned TXC_W = $clog2(NYB + 1);

  if (TIMEOUT < 1 || W_Y_OUT < W_Y) begin : g_bad_params
    $error("mvm_uart_framer: TIMEOUT must be >= 1 and W_Y_OUT >= W_Y");
  end

  typedef enum logic [2:0] {RX_IDLE, RX_MODE, RX_KPAY, RX_XPAY, RX_CHK, RX_ISSUE} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_NAK, T_ACK, T_DATA} tx_state_t;

  rx_state_t            rx_state;
  tx_state_t            tx_state;
  logic [RXC_W-1:0]     rx_cnt;
  logic [TXC_W-1:0]     tx_cnt;
  logic [7:0]           chk_acc;
  logic                 mode_k;
  logic [W_KB-1:0]      k_shadow, k_reg;
  logic [W_XB-1:0]      x_shadow, x_reg;
  logic                 kx_valid;
  logic                 nak_flag;
  logic [R*W_Y_OUT-1:0] y_ext, y_sh;
  logic                 byte_valid;
  logic [7:0]           byte_data;

`ifdef MVM_FRAMER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            rx_busy;
  assign rx_busy = rx_state inside {RX_MODE, RX_KPAY, RX_XPAY, RX_CHK};
`endif

  assign bus.m_axis_kx_tvalid = kx_valid;
  assign bus.m_axis_kx_tdata  = {x_reg, k_reg};
  assign bus.m_byte_valid     = byte_valid;
  assign bus.m_byte_data      = byte_data;
  // Ready only when the Y beat will actually be taken this cycle (pending NAK wins).
  assign bus.s_axis_y_tready  = (tx_state == T_IDLE) && !nak_flag && bus.s_axis_y_tvalid;

  always_comb begin
    y_ext = '0;
    for (int unsigned r = 0; r < R; r++)
      y_ext[r*W_Y_OUT +: W_Y_OUT] = W_Y_OUT'($signed(bus.s_axis_y_tdata[r*W_Y +: W_Y]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      tx_state   <= T_IDLE;
      rx_cnt     <= '0;
      tx_cnt     <= '0;
      chk_acc    <= '0;
      mode_k     <= 1'b0;
      k_shadow   <= '0;
      k_reg      <= '0;
      x_shadow   <= '0;
      x_reg      <= '0;
      kx_valid   <= 1'b0;
      nak_flag   <= 1'b0;
      y_sh       <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
`ifdef MVM_FRAMER_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      frame_err <= 1'b0;

      // TX side first so an RX error in the same cycle re-arms the NAK flag.
      case (tx_state)
        T_IDLE: begin
          if (nak_flag) begin
            nak_flag   <= 1'b0;
            byte_data  <= 8'h15;
            byte_valid <= 1'b1;
            tx_state   <= T_NAK;
          end else if (bus.s_axis_y_tvalid) begin
            y_sh       <= y_ext;
            byte_data  <= 8'h06;
            byte_valid <= 1'b1;
            tx_state   <= T_ACK;
          end
        end
        T_NAK: if (bus.m_byte_ready) begin
          byte_valid <= 1'b0;
          tx_state   <= T_IDLE;
        end
        T_ACK: if (bus.m_byte_ready) begin
          byte_data <= y_sh[7:0];
          y_sh      <= y_sh >> 8;
          tx_cnt    <= '0;
          tx_state  <= T_DATA;
        end
        T_DATA: if (bus.m_byte_ready) begin
          if (tx_cnt == TXC_W'(NYB - 1)) begin
            byte_valid <= 1'b0;
            tx_state   <= T_IDLE;
          end else begin
            tx_cnt    <= tx_cnt + TXC_W'(1);
            byte_data <= y_sh[7:0];
            y_sh      <= y_sh >> 8;
          end
        end
        default: tx_state <= T_IDLE;
      endcase

`ifdef MVM_FRAMER_TIMEOUT_EN
      to_cnt <= (rx_busy && !bus.s_byte_valid) ? to_cnt + TO_W'(1) : '0;
`endif

      if (bus.s_byte_valid) begin
        case (rx_state)
          RX_IDLE: if (bus.s_byte_data == 8'hA5) rx_state <= RX_MODE;
          RX_MODE: begin
            if (bus.s_byte_data[7:1] != '0) begin
              frame_err <= 1'b1;
              nak_flag  <= 1'b1;
              rx_state  <= RX_IDLE;
            end else begin
              mode_k   <= bus.s_byte_data[0];
              chk_acc  <= bus.s_byte_data;
              rx_cnt   <= '0;
              rx_state <= bus.s_byte_data[0] ? RX_KPAY : RX_XPAY;
            end
          end
          RX_KPAY: begin
            k_shadow[{rx_cnt, 3'b000} +: 8] <= bus.s_byte_data;
            chk_acc <= chk_acc ^ bus.s_byte_data;
            if (rx_cnt == RXC_W'(NKB - 1)) begin
              rx_cnt   <= '0;
              rx_state <= RX_XPAY;
            end else begin
              rx_cnt <= rx_cnt + RXC_W'(1);
            end
          end
          RX_XPAY: begin
            x_shadow[{rx_cnt, 3'b000} +: 8] <= bus.s_byte_data;
            chk_acc <= chk_acc ^ bus.s_byte_data;
            if (rx_cnt == RXC_W'(NXB - 1)) begin
              rx_cnt   <= '0;
              rx_state <= RX_CHK;
            end else begin
              rx_cnt <= rx_cnt + RXC_W'(1);
            end
          end
          RX_CHK: begin
            if (bus.s_byte_data == chk_acc) begin
              if (mode_k) k_reg <= k_shadow;
              x_reg    <= x_shadow;
              kx_valid <= 1'b1;
              rx_state <= RX_ISSUE;
            end else begin
              frame_err <= 1'b1;
              nak_flag  <= 1'b1;
              rx_state  <= RX_IDLE;
            end
          end
          RX_ISSUE: frame_err <= 1'b1;
          default:  rx_state <= RX_IDLE;
        endcase
      end
`ifdef MVM_FRAMER_TIMEOUT_EN
      else if (rx_busy && to_cnt == TO_W'(TIMEOUT - 1)) begin
        frame_err <= 1'b1;
        nak_flag  <= 1'b1;
        rx_state  <= RX_IDLE;
      end
`endif

      if (rx_state == RX_ISSUE && bus.m_axis_kx_tready) begin
        kx_valid <= 1'b0;
        rx_state <= RX_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mvm_uart_framer.sv
// Directed bench for mvm_uart_framer at R=C=2, 8-bit K/X, 32-bit TX Y; models the matvec engine.
module tb_mvm_uart_framer;
  logic clk = 1'b0;
  logic rst;
  logic frame_err;
  always #5 clk = ~clk;

  mvm_uart_framer_if #(.W_KX(48), .W_Y_BUS(34)) bus ();

  mvm_uart_framer #(
    .R(2), .C(2), .W_X(8), .W_K(8), .W_Y_OUT(32), .TIMEOUT(100)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .frame_err(frame_err)
  );

  typedef struct packed {
    logic [95:0] rx;    // frame bytes, first byte most significant
    int          nrx;
    bit          beat;
    logic [47:0] kx;
    int          err;
    logic [79:0] tx;    // expected TX bytes, first byte most significant
    int          ntx;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int ph = 0;
  bit tx_slow = 1'b0;
  bit y_done = 1'b0;
  logic [47:0] kx_q[$];
  logic [7:0]  tx_q[$];
  logic [33:0] y_pend[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] matvec(input logic [47:0] kx);
    logic [33:0] y;
    int acc;
    logic signed [7:0] kv, xv;
    y = '0;
    for (int r = 0; r < 2; r++) begin
      acc = 0;
      for (int c = 0; c < 2; c++) begin
        kv = kx[(r*2+c)*8 +: 8];
        xv = kx[32 + c*8 +: 8];
        acc += int'(kv) * int'(xv);
      end
      y[r*17 +: 17] = acc[16:0];
    end
    return y;
  endfunction

  // Observers: every handshake is judged at the negedge preceding the edge that takes it.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_axis_kx_tvalid && bus.m_axis_kx_tready) begin
        kx_q.push_back(bus.m_axis_kx_tdata);
        y_pend.push_back(matvec(bus.m_axis_kx_tdata));
      end
      if (bus.m_byte_valid && bus.m_byte_ready) tx_q.push_back(bus.m_byte_data);
      if (frame_err) err_cnt++;
      if (bus.s_axis_y_tvalid && bus.s_axis_y_tready) y_done = 1'b1;
    end
  end

  initial begin
    bus.s_axis_y_tvalid = 1'b0;
    bus.s_axis_y_tdata  = '0;
    forever begin
      @(posedge clk); #1;
      if (y_done) begin
        bus.s_axis_y_tvalid = 1'b0;
        y_done = 1'b0;
      end
      if (!bus.s_axis_y_tvalid && y_pend.size() > 0) begin
        bus.s_axis_y_tdata  = y_pend.pop_front();
        bus.s_axis_y_tvalid = 1'b1;
      end
    end
  end

  initial begin
    bus.m_byte_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ph++;
      bus.m_byte_ready = tx_slow ? (ph % 3 == 0) : 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.s_byte_valid = 1'b1;
    bus.s_byte_data  = b;
    @(posedge clk); #1;
    bus.s_byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [95:0] rx, input int nrx);
    for (int i = 0; i < nrx; i++) send_byte(rx[(nrx-1-i)*8 +: 8]);
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (tx_q.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    kx_q.delete();
    tx_q.delete();
    err_cnt = 0;
  endtask

  task automatic check_tx(input string tag, input logic [79:0] tx, input int ntx);
    check({tag, ".tx_count"}, tx_q.size(), ntx);
    for (int i = 0; i < ntx; i++)
      check($sformatf("%s.tx[%0d]", tag, i),
            (i < tx_q.size()) ? {56'h0, tx_q[i]} : 64'hDEAD, {56'h0, tx[(ntx-1-i)*8 +: 8]});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".m_byte_valid"}, bus.m_byte_valid, 0);
    check({tag, ".m_byte_data"},  bus.m_byte_data, 0);
    check({tag, ".kx_tvalid"},    bus.m_axis_kx_tvalid, 0);
    check({tag, ".kx_tdata"},     bus.m_axis_kx_tdata, 0);
    check({tag, ".y_tready"},     bus.s_axis_y_tready, 0);
    check({tag, ".frame_err"},    frame_err, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.s_byte_valid = 1'b0;
    bus.s_byte_data  = '0;
    bus.m_axis_kx_tready = 1'b1;

    vecs[0] = '{96'hA5_01_01_02_03_04_05_06_06, 9, 1'b1, 48'h0605_04030201, 0,
                80'h06_11000000_27000000, 9};
    vecs[1] = '{96'hA5_00_FF_01_FE, 5, 1'b1, 48'h01FF_04030201, 0,
                80'h06_01000000_01000000, 9};
    vecs[2] = '{96'hA5_00_FD_00_FD, 5, 1'b1, 48'h00FD_04030201, 0,
                80'h06_FDFFFFFF_F7FFFFFF, 9};
    vecs[3] = '{96'hA5_01_09_09_09_09_01_01_00, 9, 1'b0, 48'h0, 1, 80'h15, 1};
    vecs[4] = '{96'hA5_00_05_06_03, 5, 1'b1, 48'h0605_04030201, 0,
                80'h06_11000000_27000000, 9};
    vecs[5] = '{96'hA5_02, 2, 1'b0, 48'h0, 1, 80'h15, 1};
    vecs[6] = '{96'h00_33_A5_00_01_00_01, 7, 1'b1, 48'h0001_04030201, 0,
                80'h06_01000000_03000000, 9};
    vecs[7] = '{96'hA5_01_FF_00_00_FF_02_03_00, 9, 1'b1, 48'h0302_FF0000FF, 0,
                80'h06_FEFFFFFF_FDFFFFFF, 9};

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      clear_obs();
      send_frame(vecs[v].rx, vecs[v].nrx);
      wait_tx(vecs[v].ntx, 200);
      check({tag, ".beats"}, kx_q.size(), vecs[v].beat ? 1 : 0);
      if (vecs[v].beat)
        check({tag, ".kx"}, (kx_q.size() > 0) ? {16'h0, kx_q[0]} : 64'hDEAD, {16'h0, vecs[v].kx});
      check({tag, ".frame_err"}, err_cnt, vecs[v].err);
      check_tx(tag, vecs[v].tx, vecs[v].ntx);
    end

    // KX backpressure: beat must hold, stray byte during ISSUE is dropped with an error pulse.
    clear_obs();
    bus.m_axis_kx_tready = 1'b0;
    send_frame(vecs[0].rx, vecs[0].nrx);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp.tvalid[%0d]", i), bus.m_axis_kx_tvalid, 1);
      check($sformatf("bp.tdata[%0d]", i), bus.m_axis_kx_tdata, 48'h0605_04030201);
      if (i == 4) send_byte(8'h55);
      else begin
        @(posedge clk); #1;
      end
    end
    bus.m_axis_kx_tready = 1'b1;
    wait_tx(9, 200);
    check("bp.beats", kx_q.size(), 1);
    check("bp.frame_err", err_cnt, 1);
    check_tx("bp", vecs[0].tx, 9);

    // Slow TX link with two bad frames landing mid-data: one merged NAK after the data.
    clear_obs();
    tx_slow = 1'b1;
    send_frame(vecs[4].rx, vecs[4].nrx);
    begin
      int k = 0;
      while (tx_q.size() < 3 && k < 200) begin
        @(posedge clk); #1;
        k++;
      end
    end
    send_frame(96'hA5_00_05_06_00, 5);
    send_frame(96'hA5_00_05_06_00, 5);
    wait_tx(10, 400);
    tx_slow = 1'b0;
    check("slow.beats", kx_q.size(), 1);
    check("slow.frame_err", err_cnt, 2);
    check_tx("slow", 80'h06_11000000_27000000_15, 10);

    // Reset mid-frame clears K; an X-only frame then sees K = 0.
    send_frame(96'hA5_01_01, 3);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("midrst");
    rst = 1'b0;
    clear_obs();
    send_frame(vecs[4].rx, vecs[4].nrx);
    wait_tx(9, 200);
    check("midrst.beats", kx_q.size(), 1);
    check("midrst.kx", (kx_q.size() > 0) ? {16'h0, kx_q[0]} : 64'hDEAD, 64'h0605_00000000);
    check("midrst.frame_err", err_cnt, 0);
    check_tx("midrst", 80'h06_00000000_00000000, 9);

`ifdef MVM_FRAMER_TIMEOUT_EN
    clear_obs();
    send_frame(96'hA5_00_05, 3);
    repeat (95) @(posedge clk);
    #1;
    check("to.early_err", err_cnt, 0);
    repeat (15) @(posedge clk);
    #1;
    check("to.err", err_cnt, 1);
    wait_tx(1, 100);
    check_tx("to", 80'h15, 1);
    clear_obs();
    send_frame(vecs[4].rx, vecs[4].nrx);
    wait_tx(9, 200);
    check("to.next_kx", (kx_q.size() > 0) ? {16'h0, kx_q[0]} : 64'hDEAD, 64'h0605_00000000);
    check_tx("to.next", 80'h06_00000000_00000000, 9);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
